// File: rtl/hazard_unit.sv
// Load-use hazard detection and EX operand forwarding for a 5-stage pipeline.
// Tracks the destination and load flag of the instructions in EX, MEM and WB.
module hazard_unit (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ID_Valid,
    input  logic [2:0] IRJ,
    input  logic [4:0] RS,
    input  logic [4:0] RT,
    input  logic [4:0] RD,
    input  logic       ID_RegWrite,
    input  logic       ID_Link,
    input  logic       ID_UsesRT,
    input  logic       ID_IsLoad,
    input  logic       Flush,
    output logic       Stall,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic [4:0] EX_Dest,
    output logic [7:0] StallCount
);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    logic [4:0] ex_dest_q, mem_dest_q, wb_dest_q;
    logic       ex_load_q, mem_load_q, wb_load_q;
    logic [4:0] ex_dest_d;
    logic       ex_load_d;
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    logic       irj_ok, id_live, advance;
    logic [4:0] id_dest, src_a, src_b;
    logic       a_ex, b_ex, a_mem, b_mem;

    always_comb begin
        irj_ok  = (IRJ == 3'b001) || (IRJ == 3'b010) || (IRJ == 3'b100);
        id_live = ID_Valid && irj_ok;

        id_dest = 5'd0;
        if (ID_RegWrite) begin
            case (IRJ)
                3'b010:  id_dest = RD;
                3'b001:  id_dest = ID_Link ? 5'd31 : 5'd0;
                3'b100:  id_dest = RT;
                default: id_dest = 5'd0;
            endcase
        end

        // An unused source is mapped to r0, which can never match a live destination.
        src_a = (IRJ[1] || IRJ[2]) ? RS : 5'd0;
        src_b = (IRJ[1] || (IRJ[2] && ID_UsesRT)) ? RT : 5'd0;

        a_ex  = (src_a != 5'd0) && (src_a == ex_dest_q);
        b_ex  = (src_b != 5'd0) && (src_b == ex_dest_q);
        a_mem = (src_a != 5'd0) && (src_a == mem_dest_q);
        b_mem = (src_b != 5'd0) && (src_b == mem_dest_q);

        Stall   = id_live && !Flush && ex_load_q && (ex_dest_q != 5'd0) && (a_ex || b_ex);
        advance = id_live && !Flush && !Stall;

        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (advance) begin
            if (a_ex)       fwd_a_d = FWD_EXMEM;
            else if (a_mem) fwd_a_d = FWD_MEMWB;
            if (b_ex)       fwd_b_d = FWD_EXMEM;
            else if (b_mem) fwd_b_d = FWD_MEMWB;
        end

        ex_dest_d = advance ? id_dest : 5'd0;
        ex_load_d = advance && ID_IsLoad;

        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != 8'hFF)) stall_cnt_d = stall_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_dest_q   <= 5'd0;
            ex_load_q   <= 1'b0;
            mem_dest_q  <= 5'd0;
            mem_load_q  <= 1'b0;
            wb_dest_q   <= 5'd0;
            wb_load_q   <= 1'b0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= 8'd0;
        end else begin
            ex_dest_q   <= ex_dest_d;
            ex_load_q   <= ex_load_d;
            mem_dest_q  <= ex_dest_q;
            mem_load_q  <= ex_load_q;
            wb_dest_q   <= mem_dest_q;
            wb_load_q   <= mem_load_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // The WB entry is architectural state only; nothing downstream reads it yet.
    logic unused_wb;
    assign unused_wb = ^{wb_dest_q, wb_load_q};

    assign ForwardA   = fwd_a_q;
    assign ForwardB   = fwd_b_q;
    assign EX_Dest    = ex_dest_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding selects, load-use stalls, flush,
// invalid decode, stall-counter saturation and asynchronous reset.
module tb_hazard_unit;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       ID_Valid;
    logic [2:0] IRJ;
    logic [4:0] RS, RT, RD;
    logic       ID_RegWrite, ID_Link, ID_UsesRT, ID_IsLoad, Flush;
    logic       Stall;
    logic [1:0] ForwardA, ForwardB;
    logic [4:0] EX_Dest;
    logic [7:0] StallCount;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_unit dut (
        .CLK(CLK), .RST_N(RST_N), .ID_Valid(ID_Valid), .IRJ(IRJ),
        .RS(RS), .RT(RT), .RD(RD), .ID_RegWrite(ID_RegWrite),
        .ID_Link(ID_Link), .ID_UsesRT(ID_UsesRT), .ID_IsLoad(ID_IsLoad),
        .Flush(Flush), .Stall(Stall), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .EX_Dest(EX_Dest), .StallCount(StallCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_id(input logic [2:0] irj, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic regw, input logic link,
                            input logic usesrt, input logic isload);
        ID_Valid = 1'b1; Flush = 1'b0;
        IRJ = irj; RS = rs; RT = rt; RD = rd;
        ID_RegWrite = regw; ID_Link = link; ID_UsesRT = usesrt; ID_IsLoad = isload;
    endtask

    task automatic idle(input int n);
        ID_Valid = 1'b0; Flush = 1'b0; ID_IsLoad = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RST_N = 1'b0; Flush = 1'b0;
        drive_id(3'b010, 0, 0, 0, 0, 0, 0, 0);
        ID_Valid = 1'b0;
        #12;
        check("rst_stall", {7'd0, Stall}, 8'd0);
        check("rst_fwda", {6'd0, ForwardA}, 8'd0);
        check("rst_fwdb", {6'd0, ForwardB}, 8'd0);
        check("rst_exdest", {3'd0, EX_Dest}, 8'd0);
        check("rst_cnt", StallCount, 8'd0);
        step();
        RST_N = 1'b1;
        idle(2);

        // ALU result consumed by the next instruction: EX/MEM forward, no stall
        drive_id(3'b010, 1, 2, 3, 1, 0, 0, 0);
        step();
        check("alu_exdest", {3'd0, EX_Dest}, 8'd3);
        check("alu_fwda0", {6'd0, ForwardA}, 8'd0);
        drive_id(3'b010, 3, 4, 0, 0, 0, 0, 0);
        #1 check("alu_nostall", {7'd0, Stall}, 8'd0);
        step();
        check("alu_fwda", {6'd0, ForwardA}, 8'd1);
        check("alu_fwdb", {6'd0, ForwardB}, 8'd0);
        check("alu_exdest2", {3'd0, EX_Dest}, 8'd0);
        idle(1);
        check("bubble_fwda", {6'd0, ForwardA}, 8'd0);
        idle(2);

        // Load-use: one stall cycle, then MEM/WB forward on RT
        drive_id(3'b100, 1, 5, 0, 1, 0, 0, 1);
        step();
        drive_id(3'b010, 6, 5, 7, 1, 0, 0, 0);
        #1 check("lu_stall", {7'd0, Stall}, 8'd1);
        step();
        check("lu_cnt", StallCount, 8'd1);
        check("lu_bubble", {3'd0, EX_Dest}, 8'd0);
        check("lu_stall_gone", {7'd0, Stall}, 8'd0);
        step();
        check("lu_fwdb", {6'd0, ForwardB}, 8'd2);
        check("lu_fwda", {6'd0, ForwardA}, 8'd0);
        check("lu_exdest", {3'd0, EX_Dest}, 8'd7);
        check("lu_cnt_hold", StallCount, 8'd1);
        idle(3);

        // Load r5 then I-type that does not read RT: no stall
        drive_id(3'b100, 1, 5, 0, 1, 0, 0, 1);
        step();
        drive_id(3'b100, 0, 5, 0, 1, 0, 0, 0);
        #1 check("noreadrt_stall", {7'd0, Stall}, 8'd0);
        step();
        check("noreadrt_fwda", {6'd0, ForwardA}, 8'd0);
        check("noreadrt_fwdb", {6'd0, ForwardB}, 8'd0);
        check("noreadrt_exdest", {3'd0, EX_Dest}, 8'd5);
        idle(3);

        // Load r0 then a reader of r0: never a hazard or forward
        drive_id(3'b100, 1, 0, 0, 1, 0, 0, 1);
        step();
        check("r0_exdest", {3'd0, EX_Dest}, 8'd0);
        drive_id(3'b010, 0, 0, 8, 1, 0, 0, 0);
        #1 check("r0_stall", {7'd0, Stall}, 8'd0);
        step();
        check("r0_fwda", {6'd0, ForwardA}, 8'd0);
        check("r0_fwdb", {6'd0, ForwardB}, 8'd0);
        idle(3);

        // JAL writes r31; plain J writes nothing
        drive_id(3'b001, 0, 0, 0, 1, 1, 0, 0);
        step();
        check("jal_exdest", {3'd0, EX_Dest}, 8'd31);
        drive_id(3'b010, 31, 0, 9, 1, 0, 0, 0);
        step();
        check("jal_fwda", {6'd0, ForwardA}, 8'd1);
        idle(3);
        drive_id(3'b001, 0, 0, 0, 1, 0, 0, 0);
        step();
        check("j_exdest", {3'd0, EX_Dest}, 8'd0);
        drive_id(3'b010, 31, 0, 9, 1, 0, 0, 0);
        step();
        check("j_fwda", {6'd0, ForwardA}, 8'd0);
        idle(3);

        // MEM/WB forward across a bubble, and EX priority over MEM
        drive_id(3'b010, 0, 0, 10, 1, 0, 0, 0);
        step();
        idle(1);
        drive_id(3'b010, 10, 0, 12, 1, 0, 0, 0);
        step();
        check("mem_fwda", {6'd0, ForwardA}, 8'd2);
        idle(3);
        drive_id(3'b010, 0, 0, 11, 1, 0, 0, 0);
        step();
        drive_id(3'b010, 0, 0, 11, 1, 0, 0, 0);
        step();
        drive_id(3'b010, 0, 11, 13, 1, 0, 0, 0);
        step();
        check("prio_fwdb", {6'd0, ForwardB}, 8'd1);
        idle(3);

        // Flush wins over a load-use hazard
        drive_id(3'b100, 1, 5, 0, 1, 0, 0, 1);
        step();
        drive_id(3'b010, 5, 0, 7, 1, 0, 0, 0);
        Flush = 1'b1;
        #1 check("flush_stall", {7'd0, Stall}, 8'd0);
        step();
        check("flush_exdest", {3'd0, EX_Dest}, 8'd0);
        check("flush_cnt", StallCount, 8'd1);
        idle(3);

        // Invalid (non one-hot) IRJ behaves as no instruction
        drive_id(3'b100, 1, 5, 0, 1, 0, 0, 1);
        step();
        drive_id(3'b011, 5, 5, 6, 1, 0, 1, 0);
        #1 check("badirj_stall", {7'd0, Stall}, 8'd0);
        step();
        check("badirj_exdest", {3'd0, EX_Dest}, 8'd0);
        idle(3);

        // Self-dependent load repeated: a stall every other cycle, well over 255
        drive_id(3'b100, 5, 5, 0, 1, 0, 0, 1);
        for (int i = 0; i < 620; i++) step();
        check("sat_cnt", StallCount, 8'd255);
        idle(3);

        // Asynchronous reset during a stall
        drive_id(3'b100, 1, 5, 0, 1, 0, 0, 1);
        step();
        drive_id(3'b010, 6, 5, 7, 1, 0, 0, 0);
        #1 check("ar_stall_pre", {7'd0, Stall}, 8'd1);
        #2 RST_N = 1'b0;
        #1;
        check("ar_stall", {7'd0, Stall}, 8'd0);
        check("ar_exdest", {3'd0, EX_Dest}, 8'd0);
        check("ar_cnt", StallCount, 8'd0);
        #1 RST_N = 1'b1;
        step();
        check("ar_post_exdest", {3'd0, EX_Dest}, 8'd7);
        check("ar_post_fwdb", {6'd0, ForwardB}, 8'd0);
        check("ar_post_cnt", StallCount, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
